// File: rtl/irq_priority_arbiter.sv
// Interrupt dispatch controller: masks the pending bitmap, picks one interrupt,
// runs req/grant/done with the core and acks the capture stage. IRQ_RR_EN selects round-robin.
module irq_priority_arbiter (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_irq_pending,
   input  logic        i_cfg_wren,
   input  logic        i_cfg_addr,
   input  logic [31:0] i_cfg_wdata,
   output logic [31:0] o_cfg_rdata,
   output logic        o_irq_req,
   output logic [4:0]  o_irq_id,
   input  logic        i_irq_grant,
   input  logic        i_irq_done,
   output logic        o_irq_ack,
   output logic [4:0]  o_irq_ack_id
);

   localparam int unsigned IRQ_W = 32;
   localparam int unsigned ID_W  = 5;
   localparam int unsigned ST_W  = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_REQ     = 3'd2,
      ST_SERVICE = 3'd3,
      ST_ACK     = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [IRQ_W-1:0]  mask_q;
   logic              gen_q;
   logic [IRQ_W-1:0]  eligible;
   logic [ID_W-1:0]   winner;
   logic              req_d;
   logic              ack_d;

   // Software-visible configuration registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mask_q <= '0;
         gen_q  <= 1'b0;
      end else if (i_cfg_wren) begin
         if (i_cfg_addr) begin
            gen_q <= i_cfg_wdata[0];
         end else begin
            mask_q <= i_cfg_wdata;
         end
      end
   end

   always_comb begin
      o_cfg_rdata = '0;
      if (i_cfg_addr) begin
         o_cfg_rdata = {19'd0, o_irq_id, 1'b0, state_q, 3'd0, gen_q};
      end else begin
         o_cfg_rdata = mask_q;
      end
   end

   assign eligible = gen_q ? (i_irq_pending & mask_q) : '0;

`ifdef IRQ_RR_EN
   logic [ID_W-1:0] ptr_q;

   // Round-robin search starting at ptr_q, wrapping 31 -> 0
   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < int'(IRQ_W); i++) begin
         idx = ptr_q + ID_W'(i);
         if (!found && eligible[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Pointer advances past the serviced id; withdraws leave it untouched
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
      end else if (state_q == ST_ACK) begin
         ptr_q <= o_irq_id + ID_W'(1);
      end
   end
`else
   // Fixed priority: lowest set index wins
   always_comb begin
      winner = '0;
      for (int i = int'(IRQ_W) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = ID_W'(i);
         end
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-output decode; grant takes precedence over withdraw
   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      ack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            state_d = (|eligible) ? ST_REQ : ST_IDLE;
         end
         ST_REQ: begin
            if (i_irq_grant) begin
               state_d = ST_SERVICE;
            end else if (!eligible[o_irq_id]) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (i_irq_done) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      req_d = (state_d == ST_REQ);
      ack_d = (state_d == ST_ACK);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_irq_id     <= '0;
         o_irq_req    <= 1'b0;
         o_irq_ack    <= 1'b0;
         o_irq_ack_id <= '0;
      end else begin
         if ((state_q == ST_ARB) && (|eligible)) begin
            o_irq_id <= winner;
         end
         o_irq_req    <= req_d;
         o_irq_ack    <= ack_d;
         o_irq_ack_id <= ack_d ? o_irq_id : '0;
      end
   end

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Self-checking bench for irq_priority_arbiter; covers both the fixed and IRQ_RR_EN builds.
module tb_irq_priority_arbiter;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_irq_pending;
   logic        i_cfg_wren;
   logic        i_cfg_addr;
   logic [31:0] i_cfg_wdata;
   logic [31:0] o_cfg_rdata;
   logic        o_irq_req;
   logic [4:0]  o_irq_id;
   logic        i_irq_grant;
   logic        i_irq_done;
   logic        o_irq_ack;
   logic [4:0]  o_irq_ack_id;

   int          n_cmp;
   int          n_mis;
   int          ack_count;
   logic [4:0]  exp_q[$];

   irq_priority_arbiter dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_irq_pending(i_irq_pending),
      .i_cfg_wren   (i_cfg_wren),
      .i_cfg_addr   (i_cfg_addr),
      .i_cfg_wdata  (i_cfg_wdata),
      .o_cfg_rdata  (o_cfg_rdata),
      .o_irq_req    (o_irq_req),
      .o_irq_id     (o_irq_id),
      .i_irq_grant  (i_irq_grant),
      .i_irq_done   (i_irq_done),
      .o_irq_ack    (o_irq_ack),
      .o_irq_ack_id (o_irq_ack_id)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_irq_ack) ack_count <= ack_count + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic cfg_write(input logic addr, input logic [31:0] data);
      i_cfg_wren  = 1'b1;
      i_cfg_addr  = addr;
      i_cfg_wdata = data;
      tick();
      i_cfg_wren  = 1'b0;
   endtask

   task automatic wait_req(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (o_irq_req) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Full request/grant/done handshake; optionally clears the acked pending bit
   task automatic serve(input bit clr, output bit got_req, output logic [4:0] req_id,
                        output bit got_ack, output logic [4:0] ack_id);
      got_ack = 1'b0;
      ack_id  = '0;
      req_id  = '0;
      wait_req(got_req);
      if (got_req) begin
         req_id      = o_irq_id;
         i_irq_grant = 1'b1;
         tick();
         i_irq_grant = 1'b0;
         tick();
         i_irq_done  = 1'b1;
         tick();
         i_irq_done  = 1'b0;
         got_ack     = o_irq_ack;
         ack_id      = o_irq_ack_id;
         if (clr && got_ack) i_irq_pending[ack_id] = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_irq_pending = '0; i_cfg_wren = 1'b0; i_cfg_addr = 1'b0;
      i_cfg_wdata = '0; i_irq_grant = 1'b0; i_irq_done = 1'b0;
      tick(); tick(); tick();
      i_rst_n = 1'b1;
      tick();
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL reset_req got=%b exp=0", o_irq_req); end
      n_cmp++; if (o_irq_id !== 5'd0) begin n_mis++; $display("FAIL reset_id got=%0d exp=0", o_irq_id); end
      n_cmp++; if (o_irq_ack !== 1'b0) begin n_mis++; $display("FAIL reset_ack got=%b exp=0", o_irq_ack); end
      n_cmp++; if (o_irq_ack_id !== 5'd0) begin n_mis++; $display("FAIL reset_ack_id got=%0d exp=0", o_irq_ack_id); end
      i_cfg_addr = 1'b0; #1;
      n_cmp++; if (o_cfg_rdata !== 32'h0) begin n_mis++; $display("FAIL reset_mask got=%h exp=0", o_cfg_rdata); end
      i_cfg_addr = 1'b1; #1;
      n_cmp++; if (o_cfg_rdata !== 32'h0) begin n_mis++; $display("FAIL reset_status got=%h exp=0", o_cfg_rdata); end
   endtask

   task automatic test_order();
      bit         gr, ga;
      logic [4:0] rid, aid, exp;
`ifdef IRQ_RR_EN
      i_irq_pending = 32'h8000_0001;
      exp_q.push_back(5'd0); exp_q.push_back(5'd31);
      exp_q.push_back(5'd0); exp_q.push_back(5'd31);
`else
      i_irq_pending = 32'h8000_0011;
      exp_q.push_back(5'd0); exp_q.push_back(5'd4); exp_q.push_back(5'd31);
`endif
      cfg_write(1'b0, 32'hFFFF_FFFF);
      cfg_write(1'b1, 32'h1);
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
`ifdef IRQ_RR_EN
         serve(1'b0, gr, rid, ga, aid);
`else
         serve(1'b1, gr, rid, ga, aid);
`endif
         n_cmp++; if (gr !== 1'b1 || ga !== 1'b1) begin n_mis++; $display("FAIL order_handshake req=%b ack=%b exp=1/1", gr, ga); end
         n_cmp++; if (rid !== exp) begin n_mis++; $display("FAIL order_req_id got=%0d exp=%0d", rid, exp); end
         n_cmp++; if (aid !== exp) begin n_mis++; $display("FAIL order_ack_id got=%0d exp=%0d", aid, exp); end
      end
      i_irq_pending = '0;
      tick(); tick();
   endtask

   task automatic test_single();
      logic [4:0] exp;
      cfg_write(1'b0, 32'h0000_0008);
      tick();
      i_irq_pending = 32'h8;
      exp_q.push_back(5'd3);
      tick();
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL single_req_n1 got=%b exp=0", o_irq_req); end
      tick();
      n_cmp++; if (o_irq_req !== 1'b1) begin n_mis++; $display("FAIL single_req_n2 got=%b exp=1", o_irq_req); end
      n_cmp++; if (o_irq_id !== 5'd3) begin n_mis++; $display("FAIL single_id got=%0d exp=3", o_irq_id); end
      tick();
      i_irq_grant = 1'b1;
      tick();
      i_irq_grant = 1'b0;
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL single_req_after_grant got=%b exp=0", o_irq_req); end
      tick();
      n_cmp++; if (o_irq_ack !== 1'b0) begin n_mis++; $display("FAIL single_early_ack got=%b exp=0", o_irq_ack); end
      tick();
      i_irq_done = 1'b1;
      tick();
      i_irq_done = 1'b0;
      n_cmp++; if (o_irq_ack !== 1'b1) begin n_mis++; $display("FAIL single_ack got=%b exp=1", o_irq_ack); end
      exp = exp_q.pop_front();
      n_cmp++; if (o_irq_ack_id !== exp) begin n_mis++; $display("FAIL single_ack_id got=%0d exp=%0d", o_irq_ack_id, exp); end
      i_irq_pending = '0;
      tick();
      n_cmp++; if (o_irq_ack !== 1'b0) begin n_mis++; $display("FAIL single_ack_width got=%b exp=0", o_irq_ack); end
      tick();
   endtask

   task automatic test_masking_gen();
      int         req_seen;
      logic [4:0] exp_id;
      cfg_write(1'b1, 32'h0);
      cfg_write(1'b0, 32'h0000_00FF);
      i_irq_pending = 32'hFF;
      req_seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (o_irq_req) req_seen++;
      end
      n_cmp++; if (req_seen !== 0) begin n_mis++; $display("FAIL gen_off_req got=%0d cycles exp=0", req_seen); end
`ifdef IRQ_RR_EN
      exp_id = 5'd4;
`else
      exp_id = 5'd0;
`endif
      cfg_write(1'b1, 32'h1);
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL gen_on_req_e0 got=%b exp=0", o_irq_req); end
      tick();
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL gen_on_req_e1 got=%b exp=0", o_irq_req); end
      tick();
      n_cmp++; if (o_irq_req !== 1'b1) begin n_mis++; $display("FAIL gen_on_req_e2 got=%b exp=1", o_irq_req); end
      n_cmp++; if (o_irq_id !== exp_id) begin n_mis++; $display("FAIL gen_on_id got=%0d exp=%0d", o_irq_id, exp_id); end
      i_irq_pending = '0;
      tick(); tick();
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL pending_drop_req got=%b exp=0", o_irq_req); end
   endtask

   task automatic test_withdraw();
      bit seen;
      int acks_before;
      i_irq_pending = 32'h20;
      wait_req(seen);
      n_cmp++; if (seen !== 1'b1) begin n_mis++; $display("FAIL withdraw_req_timeout got=%b exp=1", seen); end
      n_cmp++; if (o_irq_id !== 5'd5) begin n_mis++; $display("FAIL withdraw_id got=%0d exp=5", o_irq_id); end
      acks_before = ack_count;
      cfg_write(1'b0, 32'h0000_00DF);
      tick();
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL withdraw_req got=%b exp=0", o_irq_req); end
      i_cfg_addr = 1'b1; #1;
      n_cmp++; if (o_cfg_rdata[6:4] !== 3'd0) begin n_mis++; $display("FAIL withdraw_state got=%0d exp=0", o_cfg_rdata[6:4]); end
      i_irq_pending = '0;
      for (int k = 0; k < 8; k++) tick();
      n_cmp++; if (ack_count !== acks_before) begin n_mis++; $display("FAIL withdraw_no_ack got=%0d exp=%0d", ack_count, acks_before); end
   endtask

   task automatic test_reset_service();
      bit seen;
      int acks_before;
      cfg_write(1'b0, 32'h0000_0002);
      i_irq_pending = 32'h2;
      wait_req(seen);
      n_cmp++; if (seen !== 1'b1) begin n_mis++; $display("FAIL rst_svc_req_timeout got=%b exp=1", seen); end
      i_irq_grant = 1'b1;
      tick();
      i_irq_grant = 1'b0;
      i_cfg_addr = 1'b1; #1;
      n_cmp++; if (o_cfg_rdata !== 32'h0000_0131) begin n_mis++; $display("FAIL rst_svc_status got=%h exp=00000131", o_cfg_rdata); end
      acks_before = ack_count;
      tick();
      i_rst_n = 1'b0;
      #1;
      n_cmp++; if ({o_irq_req, o_irq_id, o_irq_ack, o_irq_ack_id} !== 12'h0) begin
         n_mis++; $display("FAIL rst_svc_outputs got req=%b id=%0d ack=%b ack_id=%0d exp=all 0",
                           o_irq_req, o_irq_id, o_irq_ack, o_irq_ack_id);
      end
      tick(); tick();
      i_rst_n = 1'b1;
      tick();
      i_cfg_addr = 1'b1; #1;
      n_cmp++; if (o_cfg_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_svc_status_after got=%h exp=0", o_cfg_rdata); end
      i_cfg_addr = 1'b0; #1;
      n_cmp++; if (o_cfg_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_svc_mask_after got=%h exp=0", o_cfg_rdata); end
      for (int k = 0; k < 6; k++) tick();
      n_cmp++; if (ack_count !== acks_before) begin n_mis++; $display("FAIL rst_svc_no_ack got=%0d exp=%0d", ack_count, acks_before); end
      n_cmp++; if (o_irq_req !== 1'b0) begin n_mis++; $display("FAIL rst_svc_req_after got=%b exp=0", o_irq_req); end
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      ack_count = 0;
      test_reset();
      test_order();
      test_single();
      test_masking_gen();
      test_withdraw();
      test_reset_service();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
